usr_seq_ctrl: RTL and testbench
===============================

Name: usr_seq_ctrl

Overview:
Command sequencer for the team's 4-bit universal shift register. It accepts one command at a time over a valid/ready interface (LOAD, HOLD, shift-right-N, shift-left-N). It drives the register's MODE and DATAIN cycle by cycle, feeding fill bits serially from the command data. On completion it returns the register contents with a one-cycle done pulse.

Parameters:
WIDTH, 4, register width; must match the controlled register.
CNT_W, 3, shift-counter width; must satisfy 2**CNT_W > WIDTH.

Ports:
clock  input  1  sole clock; all state updates on posedge.
reset  input  1  synchronous, active-high reset.
cmd_valid  input  1  command present.
cmd_ready  output  1  controller can accept a command (high only in IDLE).
cmd_op  input  2  00 HOLD, 01 SHR, 10 SHL, 11 LOAD.
cmd_count  input  CNT_W  number of shifts for SHR/SHL; ignored otherwise.
cmd_data  input  WIDTH  LOAD value, or serial fill bits, consumed LSB first.
usr_mode  output  2  MODE to the shift register.
usr_datain  output  WIDTH  DATAIN to the shift register.
usr_dataout  input  WIDTH  DATAOUT from the shift register.
busy  output  1  command in progress (state != IDLE).
done  output  1  one-cycle completion pulse.
result  output  WIDTH  register contents captured at completion; held until the next done.

Behaviour:
- Clock and reset: one clock. Reset is synchronous and active-high. Ports are named clock and reset.
- Reset values: state=IDLE, cmd_ready=1, usr_mode=00, usr_datain=0, busy=0, done=0, result=0, counter=0, latched data=0.
- Reset mid-operation: next state is IDLE, with no done pulse. The register shares the same reset and clears to 0.
- States: IDLE, LOAD, SHIFT, DONE.
- Outputs: usr_mode, usr_datain, cmd_ready, busy and done decode from registered state only.
- IDLE:
  - usr_mode=00 (hold), cmd_ready=1.
  - Accept when cmd_valid&&cmd_ready, at cycle T. Latch op, data and the effective count.
  - Effective count = min(cmd_count, WIDTH).
- Transitions from IDLE on accept:
  - LOAD -> LOAD.
  - SHR or SHL with effective count > 0 -> SHIFT.
  - HOLD, or SHR/SHL with count 0 -> DONE.
- LOAD state (one cycle): usr_mode=11, usr_datain=latched data. Next state DONE.
- SHIFT state:
  - usr_mode = 01 for SHR, 10 for SHL.
  - usr_datain = {0…, latched_data[0]}.
  - Each cycle: latched data shifts right by 1 and the counter decrements.
  - Leave to DONE when the counter is 1 this cycle. Exactly N shift cycles occur.
- DONE state (one cycle):
  - usr_mode=00, done=1, result<=usr_dataout.
  - Next state IDLE. cmd_ready is low here, so back-to-back commands are spaced by at least one IDLE cycle.
- Latency from accept cycle T:
  - LOAD: done at T+2.
  - SHIFT N: done at T+N+1.
  - HOLD / count 0: done at T+1.
- Register semantics relied on:
  - SHR inserts DATAIN[0] at the MSB.
  - SHL inserts it at the LSB.
- cmd_valid while busy: ignored. The command is not consumed, and the requester must hold it.
- cmd_count values above WIDTH saturate to WIDTH.

Decomposition:
- Package usr_pkg:
  - mode constants MODE_HOLD=2'b00, MODE_SHR=2'b01, MODE_SHL=2'b10, MODE_LOAD=2'b11.
  - op enum (same encoding as the mode constants).
  - state enum {IDLE, LOAD, SHIFT, DONE}.
  - WIDTH default.
- Sub-module usr_shift_counter: loadable CNT_W down-counter with a last flag.
- The bench instantiates usr_seq_ctrl together with the 4-bit universal shift register.

Test Plan:
- Reset, then LOAD 4'b1010 accepted at T -> usr_mode=11 at T+1; done=1 with result=4'b1010 at T+2; busy low at T+3.
- After register=1010, SHR count=2 data=4'b0011 -> register 1101 then 1110; done at T+3, result=4'b1110.
- After register=1110, SHL count=3 data=4'b0101 -> register 1101, 1010, 0101; done at T+4, result=4'b0101.
- SHR count=0, and HOLD -> each gives done at T+1 with result equal to current register; usr_mode stays 00 throughout.
- SHL count=7 on register 0000 with data=4'b1111 -> saturates to 4 shifts; done at T+5, result=4'b1111.
- Reset asserted during the 2nd cycle of a 4-shift command -> next cycle state=IDLE, cmd_ready=1, no done pulse, result=0. A command held on cmd_valid during busy is accepted only once IDLE is reached.

Source files
------------

// File: rtl/usr_pkg.sv
// -----------------------------------------------------------------------------
// usr_pkg
// Shared definitions for the universal shift register command sequencer.
//
// Contents:
//   WIDTH_DEF  default register width
//   MODE_*     MODE encodings understood by the 4-bit universal shift register
//   op_e       command opcodes (same encoding as the MODE values)
//   state_e    sequencer states
// -----------------------------------------------------------------------------
package usr_pkg;

  localparam int WIDTH_DEF = 4;

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_SHR  = 2'b01;
  localparam logic [1:0] MODE_SHL  = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  // Opcodes share the MODE encoding so a command maps directly onto a MODE.
  typedef enum logic [1:0] {
    OP_HOLD = 2'b00,
    OP_SHR  = 2'b01,
    OP_SHL  = 2'b10,
    OP_LOAD = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    LOAD  = 2'b01,
    SHIFT = 2'b10,
    DONE  = 2'b11
  } state_e;

endpackage

// File: rtl/usr_shift_counter.sv
// -----------------------------------------------------------------------------
// usr_shift_counter
// Loadable down-counter that tracks the remaining shift cycles of a command.
//
// Ports:
//   clock       sole clock, posedge
//   reset       synchronous, active-high; clears count to 0
//   load        load load_value (takes priority over dec)
//   load_value  number of shifts to perform
//   dec         decrement by one (saturates at 0)
//   count       current remaining count
//   last        high while count == 1, i.e. this is the final shift cycle
// -----------------------------------------------------------------------------
module usr_shift_counter #(
  parameter int CNT_W = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_value,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic             last
);

  // Count register. Load wins over decrement; decrement never wraps below 0
  // so a stray dec in an unexpected state cannot produce a huge count.
  always_ff @(posedge clock) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  // The sequencer leaves SHIFT during the cycle in which count is 1, which
  // gives exactly load_value shift cycles.
  assign last = (count == CNT_W'(1));

endmodule

// File: rtl/usr_seq_ctrl.sv
// -----------------------------------------------------------------------------
// usr_seq_ctrl
// Command sequencer for the 4-bit universal shift register. Accepts one command
// at a time (HOLD, SHR-N, SHL-N, LOAD), drives MODE/DATAIN cycle by cycle,
// feeds fill bits serially LSB first, and returns the register contents with
// a one-cycle done pulse.
//
// Ports:
//   clock        sole clock, posedge
//   reset        synchronous, active-high
//   cmd_valid    command present
//   cmd_ready    command can be accepted (high only in IDLE)
//   cmd_op       00 HOLD, 01 SHR, 10 SHL, 11 LOAD
//   cmd_count    shift count for SHR/SHL, saturated to WIDTH
//   cmd_data     LOAD value, or serial fill bits consumed LSB first
//   usr_mode     MODE to the shift register
//   usr_datain   DATAIN to the shift register
//   usr_dataout  DATAOUT from the shift register
//   busy         command in progress
//   done         one-cycle completion pulse
//   result       register contents captured in DONE, held until next done
// -----------------------------------------------------------------------------
module usr_seq_ctrl
  import usr_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_count,
  input  logic [WIDTH-1:0] cmd_data,
  output logic [1:0]       usr_mode,
  output logic [WIDTH-1:0] usr_datain,
  input  logic [WIDTH-1:0] usr_dataout,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam logic [CNT_W-1:0] WIDTH_CNT = CNT_W'(WIDTH);

  state_e           state;
  state_e           state_next;
  op_e              op_q;
  logic [WIDTH-1:0] data_q;
  logic [CNT_W-1:0] eff_count;
  logic [CNT_W-1:0] shift_count;
  logic             shift_last;
  logic             accept;

  // A command is consumed only when the controller is idle; anything
  // presented while busy stays on the bus until IDLE comes back.
  assign accept = cmd_valid && (state == IDLE);

  // Counts above WIDTH would only push the fill bits back out, so saturate.
  assign eff_count = (cmd_count > WIDTH_CNT) ? WIDTH_CNT : cmd_count;

  usr_shift_counter #(
    .CNT_W(CNT_W)
  ) u_counter (
    .clock      (clock),
    .reset      (reset),
    .load       (accept),
    .load_value (eff_count),
    .dec        (state == SHIFT),
    .count      (shift_count),
    .last       (shift_last)
  );

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic. A zero-length shift or a HOLD skips straight to DONE
  // so the requester still gets its done pulse and the current contents.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (accept) begin
          unique case (op_e'(cmd_op))
            OP_LOAD: state_next = LOAD;
            OP_SHR,
            OP_SHL:  state_next = (eff_count != '0) ? SHIFT : DONE;
            default: state_next = DONE;
          endcase
        end
      end
      LOAD:    state_next = DONE;
      SHIFT:   state_next = shift_last ? DONE : SHIFT;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output decode from the registered state (plus the latched command).
  // During SHIFT the fill bit always rides on DATAIN[0]; the register itself
  // decides whether it lands at the MSB (SHR) or LSB (SHL).
  always_comb begin
    usr_mode   = MODE_HOLD;
    usr_datain = '0;
    cmd_ready  = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    unique case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
      end
      LOAD: begin
        usr_mode   = MODE_LOAD;
        usr_datain = data_q;
      end
      SHIFT: begin
        usr_mode   = (op_q == OP_SHL) ? MODE_SHL : MODE_SHR;
        usr_datain = {{(WIDTH-1){1'b0}}, data_q[0]};
      end
      DONE: begin
        done = 1'b1;
      end
      default: begin
        busy = 1'b1;
      end
    endcase
  end

  // Command datapath: latch op/data on accept, walk the fill bits down to
  // bit 0 one per shift cycle, and capture the register contents in DONE.
  always_ff @(posedge clock) begin
    if (reset) begin
      op_q   <= OP_HOLD;
      data_q <= '0;
      result <= '0;
    end else begin
      if (accept) begin
        op_q   <= op_e'(cmd_op);
        data_q <= cmd_data;
      end else if (state == SHIFT) begin
        data_q <= data_q >> 1;
      end
      if (state == DONE) begin
        result <= usr_dataout;
      end
    end
  end

endmodule

// File: tb/tb_usr_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_usr_seq_ctrl
// Directed bench for usr_seq_ctrl driving a 4-bit universal shift register.
// -----------------------------------------------------------------------------
module tb_usr_seq_ctrl;
  import usr_pkg::*;

  localparam int WIDTH = 4;
  localparam int CNT_W = 3;

  logic             clock;
  logic             reset;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [CNT_W-1:0] cmd_count;
  logic [WIDTH-1:0] cmd_data;
  logic [1:0]       usr_mode;
  logic [WIDTH-1:0] usr_datain;
  logic [WIDTH-1:0] usr_dataout;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;

  logic [WIDTH-1:0] shreg;

  int compare_count  = 0;
  int mismatch_count = 0;

  usr_seq_ctrl #(
    .WIDTH(WIDTH),
    .CNT_W(CNT_W)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_op      (cmd_op),
    .cmd_count   (cmd_count),
    .cmd_data    (cmd_data),
    .usr_mode    (usr_mode),
    .usr_datain  (usr_datain),
    .usr_dataout (usr_dataout),
    .busy        (busy),
    .done        (done),
    .result      (result)
  );

  // The controlled 4-bit universal shift register: SHR inserts DATAIN[0] at
  // the MSB, SHL inserts it at the LSB, and it shares the controller's reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      shreg <= '0;
    end else begin
      case (usr_mode)
        MODE_SHR:  shreg <= {usr_datain[0], shreg[WIDTH-1:1]};
        MODE_SHL:  shreg <= {shreg[WIDTH-2:0], usr_datain[0]};
        MODE_LOAD: shreg <= usr_datain;
        default:   shreg <= shreg;
      endcase
    end
  end

  assign usr_dataout = shreg;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance one cycle and settle just past the rising edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic applyStimulus(input logic valid, input logic [1:0] op,
                               input logic [CNT_W-1:0] count,
                               input logic [WIDTH-1:0] data);
    cmd_valid = valid;
    cmd_op    = op;
    cmd_count = count;
    cmd_data  = data;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compare_count++;
    assert (observed === expected) else begin
      mismatch_count++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  initial begin
    reset = 1'b1;
    applyStimulus(1'b0, 2'b00, '0, '0);
    step();
    step();
    reset = 1'b0;

    // Reset state
    checkOutput("rst_ready",  32'(cmd_ready),  32'd1);
    checkOutput("rst_busy",   32'(busy),       32'd0);
    checkOutput("rst_done",   32'(done),       32'd0);
    checkOutput("rst_mode",   32'(usr_mode),   32'd0);
    checkOutput("rst_datain", 32'(usr_datain), 32'd0);
    checkOutput("rst_result", 32'(result),     32'd0);

    // LOAD 1010: mode 11 at T+1, done at T+2, idle at T+3
    $display("[TB] LOAD 1010");
    applyStimulus(1'b1, 2'b11, 3'd0, 4'b1010);
    step();
    applyStimulus(1'b0, 2'b00, 3'd0, 4'b0000);
    checkOutput("ld_mode",   32'(usr_mode),   32'h3);
    checkOutput("ld_datain", 32'(usr_datain), 32'hA);
    checkOutput("ld_ready",  32'(cmd_ready),  32'd0);
    checkOutput("ld_busy",   32'(busy),       32'd1);
    step();
    checkOutput("ld_done",   32'(done),        32'd1);
    checkOutput("ld_mode2",  32'(usr_mode),    32'h0);
    checkOutput("ld_reg",    32'(usr_dataout), 32'hA);
    step();
    checkOutput("ld_done_clr", 32'(done),   32'd0);
    checkOutput("ld_busy_clr", 32'(busy),   32'd0);
    checkOutput("ld_result",   32'(result), 32'hA);

    // SHR count=2 data=0011 on 1010 -> 1101, 1110; done at T+3
    $display("[TB] SHR 2");
    applyStimulus(1'b1, 2'b01, 3'd2, 4'b0011);
    step();
    applyStimulus(1'b0, 2'b00, 3'd0, 4'b0000);
    checkOutput("shr_mode1",   32'(usr_mode),   32'h1);
    checkOutput("shr_datain1", 32'(usr_datain), 32'h1);
    step();
    checkOutput("shr_reg1",    32'(usr_dataout), 32'hD);
    checkOutput("shr_mode2",   32'(usr_mode),    32'h1);
    checkOutput("shr_done2",   32'(done),        32'd0);
    step();
    checkOutput("shr_done",    32'(done),        32'd1);
    checkOutput("shr_reg2",    32'(usr_dataout), 32'hE);
    step();
    checkOutput("shr_result",  32'(result), 32'hE);
    checkOutput("shr_busy",    32'(busy),   32'd0);

    // SHL count=3 data=0101 on 1110 -> 1101, 1010, 0101; done at T+4
    $display("[TB] SHL 3");
    applyStimulus(1'b1, 2'b10, 3'd3, 4'b0101);
    step();
    applyStimulus(1'b0, 2'b00, 3'd0, 4'b0000);
    checkOutput("shl_mode1",   32'(usr_mode),   32'h2);
    checkOutput("shl_datain1", 32'(usr_datain), 32'h1);
    step();
    checkOutput("shl_reg1",    32'(usr_dataout), 32'hD);
    checkOutput("shl_datain2", 32'(usr_datain),  32'h0);
    step();
    checkOutput("shl_reg2",    32'(usr_dataout), 32'hA);
    checkOutput("shl_datain3", 32'(usr_datain),  32'h1);
    checkOutput("shl_done3",   32'(done),        32'd0);
    step();
    checkOutput("shl_done",    32'(done),        32'd1);
    checkOutput("shl_reg3",    32'(usr_dataout), 32'h5);
    step();
    checkOutput("shl_result",  32'(result), 32'h5);

    // SHR count=0: done at T+1, register untouched
    $display("[TB] SHR 0");
    applyStimulus(1'b1, 2'b01, 3'd0, 4'b1111);
    step();
    applyStimulus(1'b0, 2'b00, 3'd0, 4'b0000);
    checkOutput("shr0_done",   32'(done),     32'd1);
    checkOutput("shr0_mode",   32'(usr_mode), 32'h0);
    step();
    checkOutput("shr0_result", 32'(result),      32'h5);
    checkOutput("shr0_reg",    32'(usr_dataout), 32'h5);
    checkOutput("shr0_busy",   32'(busy),        32'd0);

    // HOLD: done at T+1
    $display("[TB] HOLD");
    applyStimulus(1'b1, 2'b00, 3'd4, 4'b1001);
    step();
    applyStimulus(1'b0, 2'b00, 3'd0, 4'b0000);
    checkOutput("hold_done",   32'(done),     32'd1);
    checkOutput("hold_mode",   32'(usr_mode), 32'h0);
    step();
    checkOutput("hold_result", 32'(result), 32'h5);
    checkOutput("hold_done0",  32'(done),   32'd0);

    // SHR count=4 on 0101, reset during the 2nd shift cycle
    $display("[TB] reset mid-shift");
    applyStimulus(1'b1, 2'b01, 3'd4, 4'b1111);
    step();
    applyStimulus(1'b0, 2'b00, 3'd0, 4'b0000);
    step();
    checkOutput("mid_reg1", 32'(usr_dataout), 32'hA);
    checkOutput("mid_busy", 32'(busy),        32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    checkOutput("mid_ready",  32'(cmd_ready),   32'd1);
    checkOutput("mid_busy0",  32'(busy),        32'd0);
    checkOutput("mid_done",   32'(done),        32'd0);
    checkOutput("mid_result", 32'(result),      32'h0);
    checkOutput("mid_reg0",   32'(usr_dataout), 32'h0);
    checkOutput("mid_mode",   32'(usr_mode),    32'h0);
    step();
    checkOutput("mid_done_late", 32'(done), 32'd0);

    // SHL count=7 saturates to 4 on 0000 -> 1111 at T+5; a LOAD held on
    // cmd_valid throughout is only taken once IDLE returns at T+6.
    $display("[TB] SHL 7 with held LOAD");
    applyStimulus(1'b1, 2'b10, 3'd7, 4'b1111);
    step();
    applyStimulus(1'b1, 2'b11, 3'd0, 4'b0110);
    checkOutput("sat_mode1",  32'(usr_mode),  32'h2);
    checkOutput("sat_ready1", 32'(cmd_ready), 32'd0);
    step();
    step();
    checkOutput("sat_mode3",  32'(usr_mode),    32'h2);
    checkOutput("sat_reg2",   32'(usr_dataout), 32'h3);
    step();
    checkOutput("sat_mode4",  32'(usr_mode),    32'h2);
    checkOutput("sat_reg3",   32'(usr_dataout), 32'h7);
    checkOutput("sat_done4",  32'(done),        32'd0);
    step();
    checkOutput("sat_done",   32'(done),        32'd1);
    checkOutput("sat_reg4",   32'(usr_dataout), 32'hF);
    checkOutput("sat_ready5", 32'(cmd_ready),   32'd0);
    step();
    checkOutput("sat_result", 32'(result),    32'hF);
    checkOutput("held_ready", 32'(cmd_ready), 32'd1);
    step();
    applyStimulus(1'b0, 2'b00, 3'd0, 4'b0000);
    checkOutput("held_mode",   32'(usr_mode),   32'h3);
    checkOutput("held_datain", 32'(usr_datain), 32'h6);
    step();
    checkOutput("held_done",   32'(done),        32'd1);
    checkOutput("held_reg",    32'(usr_dataout), 32'h6);
    step();
    checkOutput("held_result", 32'(result), 32'h6);
    checkOutput("held_busy",   32'(busy),   32'd0);
    step();
    checkOutput("held_once",   32'(busy),   32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, mismatch_count);
    $finish;
  end

endmodule
